regfile_dump_reader: RTL and testbench

Read-side companion to the CPU register file. On a Start pulse it walks a range of register addresses through one combinational register-file read port. It captures each word and streams {address, data} pairs out over a valid/ready handshake to the board debug path (7-seg/LED or UART formatter). It never writes the register file.

---
 rtl/regfile_dump_reader_pkg.sv | 16 +
 rtl/regfile_dump_reader_if.sv | 30 +++
 rtl/regfile_dump_reader.sv | 73 +++++++
 tb/tb_regfile_dump_reader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// Shared widths and state encoding for the register-file dump reader.
// Widths match the CPU register file defaults.
package regfile_dump_reader_pkg;

    localparam int ADDR_W = 5;
    localparam int SIZE_W = 32;
    localparam int NUMB   = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Dump-reader bus: start/range request, register-file read port, word stream out.
// master = the reader, slave = register file plus consumer side.
interface regfile_dump_reader_if #(
    parameter int ADDR = regfile_dump_reader_pkg::ADDR_W,
    parameter int SIZE = regfile_dump_reader_pkg::SIZE_W
);

    logic            Start;
    logic [ADDR-1:0] First_Addr;
    logic [ADDR-1:0] Last_Addr;
    logic [ADDR-1:0] Rd_Addr;
    logic [SIZE-1:0] Rd_Data;
    logic            Out_Valid;
    logic            Out_Ready;
    logic [ADDR-1:0] Out_Addr;
    logic [SIZE-1:0] Out_Data;
    logic            Busy;
    logic            Done;

    modport master (
        input  Start, First_Addr, Last_Addr, Rd_Data, Out_Ready,
        output Rd_Addr, Out_Valid, Out_Addr, Out_Data, Busy, Done
    );

    modport slave (
        output Start, First_Addr, Last_Addr, Rd_Data, Out_Ready,
        input  Rd_Addr, Out_Valid, Out_Addr, Out_Data, Busy, Done
    );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive, wrapping register range and streams {addr,data} words out.
// One-cycle read latency, one word per 2 cycles peak; a stalled word is held without re-reading.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int ADDR = ADDR_W,
    parameter int SIZE = SIZE_W
) (
    input  logic                  Clk,
    input  logic                  Clr,
    regfile_dump_reader_if.master bus
);

    state_t          state;
    state_t          state_nxt;
    logic [ADDR-1:0] cur;
    logic [ADDR-1:0] last;
    logic [ADDR-1:0] out_addr;
    logic [SIZE-1:0] out_data;
    logic            accept;

    assign accept = (state == SEND) && bus.Out_Ready;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Range is latched only from IDLE, so Start while busy is dropped.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            cur  <= '0;
            last <= '0;
        end else if ((state == IDLE) && bus.Start) begin
            cur  <= bus.First_Addr;
            last <= bus.Last_Addr;
        end else if (accept && (cur != last)) begin
            cur <= cur + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            out_addr <= '0;
            out_data <= '0;
        end else if (state == READ) begin
            out_addr <= cur;
            out_data <= bus.Rd_Data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Start) state_nxt = READ;
            READ:    state_nxt = SEND;
            SEND:    if (bus.Out_Ready) state_nxt = (cur == last) ? FIN : READ;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.Rd_Addr   = (state == IDLE) ? '0 : cur;
    assign bus.Out_Valid = (state == SEND);
    assign bus.Out_Addr  = out_addr;
    assign bus.Out_Data  = out_data;
    assign bus.Busy      = (state != IDLE);
    assign bus.Done      = (state == FIN);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench: expected words are queued from a register-file array when a dump starts,
// and an independent monitor pops and compares each accepted word.
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] data;
    } word_t;

    logic Clk = 1'b0;
    logic Clr;

    regfile_dump_reader_if bus ();

    logic [SIZE_W-1:0] regs [NUMB];
    word_t             exp_q [$];
    int                n_chk    = 0;
    int                n_fail   = 0;
    int                done_cnt = 0;
    int                rdy_mode = 0;

    regfile_dump_reader dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    assign bus.Rd_Data = regs[bus.Rd_Addr];

    initial forever #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Ready driver: 0 = always high, 1 = random, other = left to the main sequence.
    initial begin
        bus.Out_Ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            case (rdy_mode)
                0:       bus.Out_Ready = 1'b1;
                1:       bus.Out_Ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    initial begin
        logic  prev_stall;
        word_t prev_w;
        word_t w;
        prev_stall = 1'b0;
        prev_w     = '0;
        forever begin
            @(negedge Clk);
            if (Clr) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", bus.Out_Valid, 1);
                    chk("hold_addr", bus.Out_Addr, prev_w.addr);
                    chk("hold_data", bus.Out_Data, prev_w.data);
                end
                if (bus.Out_Valid && bus.Out_Ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got word %0h/%0h, expected none",
                                 bus.Out_Addr, bus.Out_Data);
                    end else begin
                        w = exp_q.pop_front();
                        chk("word_addr", bus.Out_Addr, w.addr);
                        chk("word_data", bus.Out_Data, w.data);
                    end
                end
                prev_stall = bus.Out_Valid && !bus.Out_Ready;
                prev_w     = {bus.Out_Addr, bus.Out_Data};
                if (bus.Done) done_cnt++;
            end
        end
    end

    // Returns one cycle after the edge that samples Start (i.e. during READ).
    task automatic do_start(input int f, input int l, input bit push);
        int n;
        int a;
        @(posedge Clk);
        #1;
        if (push) begin
            n = ((l - f + NUMB) % NUMB) + 1;
            for (int k = 0; k < n; k++) begin
                a = (f + k) % NUMB;
                exp_q.push_back({ADDR_W'(a), regs[a]});
            end
        end
        bus.Start      = 1'b1;
        bus.First_Addr = ADDR_W'(f);
        bus.Last_Addr  = ADDR_W'(l);
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge Clk);
            seen = bus.Out_Valid;
        end
        chk("valid_seen", seen, 1);
    endtask

    task automatic wait_done(input bit poke_fin);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge Clk);
            seen = bus.Done;
        end
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("busy_in_fin", bus.Busy, 1);
            if (poke_fin) begin
                bus.Start      = 1'b1;
                bus.First_Addr = ADDR_W'(20);
                bus.Last_Addr  = ADDR_W'(20);
            end
            @(posedge Clk);
            #1;
            bus.Start = 1'b0;
            @(negedge Clk);
            chk("busy_after_done", bus.Busy, 0);
            chk("done_width", bus.Done, 0);
        end
    endtask

    task automatic end_dump(input int d0);
        repeat (3) @(negedge Clk);
        chk("sb_empty", exp_q.size(), 0);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        int f_t [3];
        int l_t [3];
        int f;
        int l;
        f_t = '{30, 7, 5};
        l_t = '{1, 7, 4};
        for (int i = 0; i < NUMB; i++) regs[i] = SIZE_W'(i);
        bus.Start      = 1'b0;
        bus.First_Addr = '0;
        bus.Last_Addr  = '0;
        Clr = 1'b1;
        #1;
        chk("rst_rd_addr", bus.Rd_Addr, 0);
        chk("rst_valid", bus.Out_Valid, 0);
        chk("rst_out_addr", bus.Out_Addr, 0);
        chk("rst_out_data", bus.Out_Data, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        repeat (2) @(negedge Clk);
        Clr = 1'b0;

        // Scenario 1: cycle-exact timing with Out_Ready high.
        d0 = done_cnt;
        do_start(0, 3, 1);
        chk("s1_busy", bus.Busy, 1);
        chk("s1_valid_read", bus.Out_Valid, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge Clk);
                #1;
                chk("s1_gap", bus.Out_Valid, 0);
                chk("s1_rd_addr", bus.Rd_Addr, i);
            end
            @(posedge Clk);
            #1;
            chk("s1_valid", bus.Out_Valid, 1);
            chk("s1_addr", bus.Out_Addr, i);
        end
        @(posedge Clk);
        #1;
        chk("s1_done", bus.Done, 1);
        chk("s1_busy_fin", bus.Busy, 1);
        @(posedge Clk);
        #1;
        chk("s1_done_low", bus.Done, 0);
        chk("s1_busy_low", bus.Busy, 0);
        end_dump(d0);

        // Scenarios 2 and 3: 5-cycle stall on word 1 with a register write underneath.
        rdy_mode = 3;
        @(posedge Clk);
        #1;
        bus.Out_Ready = 1'b0;
        d0 = done_cnt;
        do_start(0, 2, 1);
        wait_valid();
        @(posedge Clk);
        #1;
        bus.Out_Ready = 1'b1;
        @(posedge Clk);
        #1;
        bus.Out_Ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("s2_stall_valid", bus.Out_Valid, 1);
            chk("s2_stall_addr", bus.Out_Addr, 1);
            chk("s2_stall_data", bus.Out_Data, 1);
            if (i == 2) regs[1] = 32'hDEADBEEF;
            @(negedge Clk);
        end
        @(posedge Clk);
        #1;
        bus.Out_Ready = 1'b1;
        wait_done(0);
        end_dump(d0);
        d0 = done_cnt;
        do_start(0, 2, 1);
        wait_done(0);
        end_dump(d0);
        regs[1] = 32'd1;

        // Scenario 4: wrap, single word, full sweep.
        rdy_mode = 0;
        for (int t = 0; t < 3; t++) begin
            d0 = done_cnt;
            do_start(f_t[t], l_t[t], 1);
            wait_done(0);
            end_dump(d0);
        end

        // Scenario 5: Start while busy and while in FIN is dropped.
        d0 = done_cnt;
        do_start(0, 3, 1);
        do_start(10, 12, 0);
        wait_done(1);
        end_dump(d0);

        // Scenario 6: Clr mid-SEND, then a clean single-word dump.
        rdy_mode = 3;
        @(posedge Clk);
        #1;
        bus.Out_Ready = 1'b0;
        d0 = done_cnt;
        do_start(0, 3, 1);
        wait_valid();
        #2;
        Clr = 1'b1;
        #1;
        chk("s6_rd_addr", bus.Rd_Addr, 0);
        chk("s6_valid", bus.Out_Valid, 0);
        chk("s6_out_addr", bus.Out_Addr, 0);
        chk("s6_out_data", bus.Out_Data, 0);
        chk("s6_busy", bus.Busy, 0);
        chk("s6_done", bus.Done, 0);
        exp_q.delete();
        repeat (3) @(negedge Clk);
        Clr = 1'b0;
        chk("s6_no_done", done_cnt - d0, 0);
        @(posedge Clk);
        #1;
        bus.Out_Ready = 1'b1;
        d0 = done_cnt;
        do_start(2, 2, 1);
        wait_done(0);
        end_dump(d0);

        // Random ranges, contents, backpressure and stray Start pulses.
        rdy_mode = 1;
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < NUMB; i++) regs[i] = $urandom;
            f  = $urandom_range(0, NUMB - 1);
            l  = $urandom_range(0, NUMB - 1);
            d0 = done_cnt;
            do_start(f, l, 1);
            if ($urandom_range(0, 1) == 1)
                do_start($urandom_range(0, NUMB - 1), $urandom_range(0, NUMB - 1), 0);
            wait_done(1'($urandom_range(0, 1)));
            end_dump(d0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
